// File: rtl/fc_seq_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package fc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_PI         = 2;
  localparam int unsigned DEF_PO         = 2;
  localparam int unsigned DEF_INNEURON   = 8;
  localparam int unsigned DEF_OUTNEURON  = 4;
  localparam int unsigned DEF_RD_LAT     = 2;
  localparam int unsigned DEF_MAC_LAT    = 1;

  // Bit width able to index n items, never below one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/fc_seq_delay_line.sv
// Enable-gated shift register that keeps beat tags aligned with delayed data.
module fc_seq_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequencer for one fully-connected layer: RAM read issue, MAC control,
// input-slice selection and one write strobe per output group.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PI         = DEF_PI,
  parameter int unsigned PO         = DEF_PO,
  parameter int unsigned INNEURON   = DEF_INNEURON,
  parameter int unsigned OUTNEURON  = DEF_OUTNEURON,
  parameter int unsigned RD_LAT     = DEF_RD_LAT,
  parameter int unsigned MAC_LAT    = DEF_MAC_LAT,
  localparam int unsigned BEATS       = INNEURON / 2,
  localparam int unsigned SLICE_BEATS = BEATS / PI,
  localparam int unsigned GROUPS      = OUTNEURON / PO,
  localparam int unsigned AW          = clog2w(SLICE_BEATS * 2),
  localparam int unsigned WAW         = clog2w(GROUPS * BEATS),
  localparam int unsigned GW          = clog2w(GROUPS),
  localparam int unsigned SW          = clog2w(PI),
  localparam int unsigned SBW         = clog2w(SLICE_BEATS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic                     in_rden,
  output logic [AW-1:0]            in_addr_a,
  output logic [AW-1:0]            in_addr_b,
  output logic                     w_rden,
  output logic [WAW-1:0]           w_addr,
  input  logic [DATA_WIDTH*PI-1:0] in_q_a_all,
  input  logic [DATA_WIDTH*PI-1:0] in_q_b_all,
  output logic [DATA_WIDTH-1:0]    in_q_a_mux,
  output logic [DATA_WIDTH-1:0]    in_q_b_mux,
  output logic                     mac_en,
  output logic                     accum_sload,
  output logic                     out_wren,
  output logic [GW-1:0]            out_addr
);

  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [SW-1:0] slice;
    logic [GW-1:0] group;
  } tag_t;

  typedef struct packed {
    logic          valid;
    logic [GW-1:0] group;
  } wtag_t;

  state_t         state, state_nx;
  logic [SBW-1:0] sbeat;
  logic [SW-1:0]  slice;
  logic [GW-1:0]  group;
  logic [WAW-1:0] wbeat;
  logic           adv_c, start_acc_c, issue_c, first_c, last_c, group_last_c, final_write_c;
  logic           busy_nx, done_nx;
  tag_t           tag_nx, tag_q, tag_out;
  wtag_t          wtag_in, wtag_pend;

  assign adv_c         = ~hold;
  assign start_acc_c   = start && ((state == IDLE) || (state == DONE));
  assign first_c       = (sbeat == '0) && (slice == '0);
  assign last_c        = (sbeat == SBW'(SLICE_BEATS - 1)) && (slice == SW'(PI - 1));
  assign group_last_c  = (group == GW'(GROUPS - 1));
  assign final_write_c = out_wren && (out_addr == GW'(GROUPS - 1));
  assign tag_nx        = '{valid: issue_c, first: first_c, last: last_c, slice: slice, group: group};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue_c  = 1'b0;
    busy_nx  = busy;
    done_nx  = done;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = ISSUE;
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue_c = 1'b1;
          if (last_c && group_last_c) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (final_write_c) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Beat/slice/group counters and registered RAM read requests.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      in_rden   <= 1'b0;
      w_rden    <= 1'b0;
      in_addr_a <= '0;
      in_addr_b <= '0;
      w_addr    <= '0;
      sbeat     <= '0;
      slice     <= '0;
      group     <= '0;
      wbeat     <= '0;
    end else begin
      busy    <= busy_nx;
      done    <= done_nx;
      in_rden <= issue_c;
      w_rden  <= issue_c;
      if (start_acc_c) begin
        sbeat <= '0;
        slice <= '0;
        group <= '0;
        wbeat <= '0;
      end else if (issue_c) begin
        in_addr_a <= AW'({sbeat, 1'b0});
        in_addr_b <= AW'({sbeat, 1'b1});
        w_addr    <= wbeat;
        wbeat     <= (last_c && group_last_c) ? '0 : wbeat + WAW'(1);
        if (sbeat == SBW'(SLICE_BEATS - 1)) begin
          sbeat <= '0;
          if (slice == SW'(PI - 1)) begin
            slice <= '0;
            group <= group_last_c ? '0 : group + GW'(1);
          end else begin
            slice <= slice + SW'(1);
          end
        end else begin
          sbeat <= sbeat + SBW'(1);
        end
      end
    end
  end

  // The tag register sits beside rden; the delay line covers the RAM latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      tag_q <= '0;
    else if (adv_c) tag_q <= tag_nx;
  end

  fc_seq_delay_line #(.WIDTH($bits(tag_t)), .DEPTH(RD_LAT)) u_rd_align (
    .clock (clock),
    .reset (reset),
    .en    (adv_c),
    .d     (tag_q),
    .q     (tag_out)
  );

  assign mac_en      = tag_out.valid & adv_c;
  assign accum_sload = tag_out.valid & tag_out.first & adv_c;

  logic [DATA_WIDTH-1:0] q_a_sl [PI];
  logic [DATA_WIDTH-1:0] q_b_sl [PI];

  for (genvar i = 0; i < int'(PI); i++) begin : g_slice
    assign q_a_sl[i] = in_q_a_all[i*DATA_WIDTH +: DATA_WIDTH];
    assign q_b_sl[i] = in_q_b_all[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_q_a_mux = tag_out.valid ? q_a_sl[tag_out.slice] : '0;
  assign in_q_b_mux = tag_out.valid ? q_b_sl[tag_out.slice] : '0;

  // Last accumulate beat of a group schedules the write MAC_LAT unstalled cycles later.
  assign wtag_in = '{valid: tag_out.valid & tag_out.last, group: tag_out.group};

  if (MAC_LAT > 1) begin : g_mac_dl
    fc_seq_delay_line #(.WIDTH($bits(wtag_t)), .DEPTH(MAC_LAT - 1)) u_mac_align (
      .clock (clock),
      .reset (reset),
      .en    (adv_c),
      .d     (wtag_in),
      .q     (wtag_pend)
    );
  end else begin : g_mac_direct
    assign wtag_pend = wtag_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_wren <= 1'b0;
      out_addr <= '0;
    end else begin
      out_wren <= adv_c & wtag_pend.valid;
      if (adv_c && wtag_pend.valid) out_addr <= wtag_pend.group;
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer at default parameters.
module tb_fc_layer_sequencer;

  localparam int DW     = 16;
  localparam int BEATS  = 4;
  localparam int SB     = 2;
  localparam int GROUPS = 2;
  localparam int BUDGET = 60;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hold  = 1'b0;
  logic        busy, done, in_rden, w_rden, mac_en, accum_sload, out_wren;
  logic [1:0]  in_addr_a, in_addr_b;
  logic [2:0]  w_addr;
  logic [0:0]  out_addr;
  logic [31:0] in_q_a_all = '0;
  logic [31:0] in_q_b_all = '0;
  logic [15:0] in_q_a_mux, in_q_b_mux;

  fc_layer_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .hold        (hold),
    .busy        (busy),
    .done        (done),
    .in_rden     (in_rden),
    .in_addr_a   (in_addr_a),
    .in_addr_b   (in_addr_b),
    .w_rden      (w_rden),
    .w_addr      (w_addr),
    .in_q_a_all  (in_q_a_all),
    .in_q_b_all  (in_q_b_all),
    .in_q_a_mux  (in_q_a_mux),
    .in_q_b_mux  (in_q_b_mux),
    .mac_en      (mac_en),
    .accum_sload (accum_sload),
    .out_wren    (out_wren),
    .out_addr    (out_addr)
  );

  always #5 clock = ~clock;

  typedef struct { logic [1:0] a; logic [1:0] b; logic [2:0] w; } rd_exp_t;
  typedef struct { logic sload; logic [15:0] ma; logic [15:0] mb; } mac_exp_t;
  typedef struct {
    logic [31:0] qa, qb;
    int hold_at, hold_len, xstart_at;
    int first_mac, wr0, wr1, done_at, macs;
  } row_t;

  rd_exp_t  rd_q[$];
  mac_exp_t mac_q[$];
  int       wr_q[$];
  row_t     rows[6];
  int       n_checks = 0;
  int       n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected beats, in issue order, for one full layer pass with constant RAM data.
  task automatic push_expected(input logic [31:0] qa, input logic [31:0] qb);
    for (int g = 0; g < GROUPS; g++) begin
      for (int b = 0; b < BEATS; b++) begin
        rd_exp_t  re;
        mac_exp_t me;
        int sl;
        sl       = b / SB;
        re.a     = 2'(2 * (b % SB));
        re.b     = 2'(2 * (b % SB) + 1);
        re.w     = 3'(g * BEATS + b);
        me.sload = (b == 0);
        me.ma    = qa[sl*DW +: DW];
        me.mb    = qb[sl*DW +: DW];
        rd_q.push_back(re);
        mac_q.push_back(me);
      end
      wr_q.push_back(g);
    end
  endtask

  task automatic run_row(input int idx, input row_t r);
    int cyc, first_mac, wr0, wr1, done_at, macs, nwr;
    rd_exp_t  re;
    mac_exp_t me;
    first_mac = -1; wr0 = -1; wr1 = -1; done_at = -1; macs = 0; nwr = 0;
    in_q_a_all = r.qa;
    in_q_b_all = r.qb;
    push_expected(r.qa, r.qb);
    @(posedge clock); #1;
    start = 1'b1;
    cyc = -1;
    for (int k = 0; k < BUDGET; k++) begin
      @(posedge clock); #1;
      cyc++;
      start = (cyc == r.xstart_at);
      hold  = (cyc >= r.hold_at) && (cyc < r.hold_at + r.hold_len);
      @(negedge clock);
      if (cyc == 0) check($sformatf("row%0d_start_state", idx), {30'd0, busy, done}, 32'h2);
      if (in_rden) begin
        check("rd_queue_nonempty", 32'(rd_q.size() != 0), 1);
        check("w_rden_with_in_rden", 32'(w_rden), 1);
        if (rd_q.size() != 0) begin
          re = rd_q.pop_front();
          check($sformatf("row%0d_rd_addrs", idx), {25'd0, in_addr_a, in_addr_b, w_addr},
                {25'd0, re.a, re.b, re.w});
        end
      end
      if (mac_en) begin
        if (first_mac < 0) first_mac = cyc;
        macs++;
        check("mac_queue_nonempty", 32'(mac_q.size() != 0), 1);
        if (mac_q.size() != 0) begin
          me = mac_q.pop_front();
          check($sformatf("row%0d_sload", idx), 32'(accum_sload), 32'(me.sload));
          check($sformatf("row%0d_mux", idx), {in_q_a_mux, in_q_b_mux}, {me.ma, me.mb});
        end
      end else if (!hold) begin
        check("idle_mux_zero", {15'd0, accum_sload, in_q_a_mux | in_q_b_mux}, 0);
      end
      if (out_wren) begin
        if (nwr == 0) wr0 = cyc; else wr1 = cyc;
        nwr++;
        check("wr_queue_nonempty", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) check($sformatf("row%0d_out_addr", idx), 32'(out_addr), 32'(wr_q.pop_front()));
      end
      if (done) begin
        done_at = cyc;
        check("busy_low_at_done", 32'(busy), 0);
        break;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    check($sformatf("row%0d_first_mac", idx), first_mac, r.first_mac);
    check($sformatf("row%0d_wr0_cycle", idx), wr0, r.wr0);
    check($sformatf("row%0d_wr1_cycle", idx), wr1, r.wr1);
    check($sformatf("row%0d_done_cycle", idx), done_at, r.done_at);
    check($sformatf("row%0d_mac_count", idx), macs, r.macs);
    check($sformatf("row%0d_queues_drained", idx), rd_q.size() + mac_q.size() + wr_q.size(), 0);
    rd_q.delete(); mac_q.delete(); wr_q.delete();
    // Done stays up, and hold has no effect, while parked in DONE.
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      hold = (k < 2);
      @(negedge clock);
      check("done_sticky_quiet", {27'd0, done, busy, in_rden, mac_en, out_wren}, 32'h10);
    end
    hold = 1'b0;
  endtask

  initial begin
    rows[0] = '{32'hBBBB_AAAA, 32'hDDDD_CCCC, -1, 0, -1, 3, 7, 11, 12, 8};
    rows[1] = '{32'h2222_1111, 32'h4444_3333,  4, 3, -1, 3, 10, 14, 15, 8};
    rows[2] = '{32'h5A5A_A5A5, 32'hFFFF_0000,  9, 2, -1, 3, 7, 13, 14, 8};
    rows[3] = '{32'h0F0F_F0F0, 32'h1234_8765,  6, 1, -1, 3, 8, 12, 13, 8};
    rows[4] = '{32'hBBBB_AAAA, 32'hDDDD_CCCC, -1, 0,  9, 3, 7, 11, 12, 8};
    rows[5] = '{32'h7777_8888, 32'h9999_6666, -1, 0,  4, 3, 7, 11, 12, 8};

    repeat (3) @(negedge clock);
    check("reset_outputs", {21'd0, busy, done, in_rden, w_rden, mac_en, accum_sload, out_wren,
                            in_addr_a, w_addr[0], out_addr}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {24'd0, busy, done, in_rden, w_rden, mac_en, out_wren, in_addr_b}, 0);

    for (int i = 0; i < 6; i++) run_row(i, rows[i]);

    // Reset during cycle 5 of a run: outputs clear at once and nothing is written.
    in_q_a_all = 32'hBBBB_AAAA;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("pre_reset_running", {30'd0, in_rden, mac_en}, 32'h3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {20'd0, busy, done, in_rden, w_rden, mac_en, accum_sload, out_wren,
                                  in_addr_a, w_addr}, 0);
    check("async_reset_mux", {in_q_a_mux, in_q_b_mux}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      check("post_abort_quiet", {27'd0, busy, done, in_rden, mac_en, out_wren}, 0);
    end

    run_row(6, rows[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
